mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port, word-organised RAM between requester 0 (CPU) and requester 1 (firmware loader / DMA).
- Latches the winning request and drives the RAM strobes for exactly one cycle.
- Returns a one-cycle ready pulse, with read data for reads, to the winning requester.
- Range-checks addresses against the RAM size; out-of-range requests complete with an error and never reach the RAM.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one word-organised RAM between a CPU (port 0) and a loader/DMA (port 1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module mem_arbiter #(
  parameter int MEM_WORDS = 1536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_wmask,
  input  logic        r0_rstrb,
  output logic        r0_ready,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_wmask,
  input  logic        r1_rstrb,
  output logic        r1_ready,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state, state_nx;
  logic [1:0]  pend;
  logic        win;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_wmask;
  logic        lat_rstrb, lat_grant, lat_err;
  logic        in_range;
  logic [31:0] done_rdata;

  assign pend     = {r1_rstrb | (|r1_wmask), r0_rstrb | (|r0_wmask)};
  assign in_range = lat_addr[31:2] < 30'(MEM_WORDS);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr;

  always_comb begin
    win = pend[1] & ~pend[0];
    if (&pend) win = ptr;
  end

  always_ff @(posedge clk) begin
    if (reset)                        ptr <= 1'b0;
    else if (state == IDLE && |pend)  ptr <= ~win;
  end
`else
  always_comb win = pend[1] & ~pend[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      lat_rstrb <= 1'b0;
      lat_grant <= 1'b0;
      lat_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |pend) begin
        lat_addr  <= win ? r1_addr  : r0_addr;
        lat_wdata <= win ? r1_wdata : r0_wdata;
        lat_wmask <= win ? r1_wmask : r0_wmask;
        lat_rstrb <= win ? r1_rstrb : r0_rstrb;
        lat_grant <= win;
      end
      if (state == ISSUE) lat_err <= ~in_range;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pend) state_nx = ISSUE;
      ISSUE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted transaction never strobes the RAM or signals ready.
  always_comb begin
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (state == ISSUE && !reset && in_range) begin
      mem_addr  = lat_addr;
      mem_rstrb = lat_rstrb;
      mem_wdata = lat_wdata;
      mem_wmask = lat_wmask;
    end
  end

  assign done_rdata = (lat_rstrb && !lat_err) ? mem_rdata : 32'h0;

  always_comb begin
    r0_ready = 1'b0;
    r0_err   = 1'b0;
    r0_rdata = '0;
    r1_ready = 1'b0;
    r1_err   = 1'b0;
    r1_rdata = '0;
    if (state == DONE && !reset) begin
      if (lat_grant) begin
        r1_ready = 1'b1;
        r1_err   = lat_err;
        r1_rdata = done_rdata;
      end else begin
        r0_ready = 1'b1;
        r0_err   = lat_err;
        r0_rdata = done_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand sequences for reset abort and contention, against a behavioural RAM.
module tb_mem_arbiter;

  localparam int MEM_WORDS = 1536;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_wmask, r1_wmask;
  logic        r0_rstrb, r1_rstrb;
  logic        r0_ready, r0_err, r1_ready, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wmask(r0_wmask), .r0_rstrb(r0_rstrb),
    .r0_ready(r0_ready), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wmask(r1_wmask), .r1_rstrb(r1_rstrb),
    .r1_ready(r1_ready), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: registered read-before-write, byte-lane writes, preload port.
  bit   [31:0] ram [0:2047];
  logic [31:0] ram_q = '0;
  logic [29:0] idx;
  logic        pre_we = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign idx       = mem_addr[31:2];
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_data;
    if (idx < 30'(MEM_WORDS)) begin
      if (mem_rstrb) ram_q <= ram[idx[10:0]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[idx[10:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input bit p, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input logic rs);
    if (p) begin
      r1_addr = a; r1_wdata = wd; r1_wmask = wm; r1_rstrb = rs;
    end else begin
      r0_addr = a; r0_wdata = wd; r0_wmask = wm; r0_rstrb = rs;
    end
  endtask

  task automatic preload(input int i, input logic [31:0] d);
    pre_idx = 11'(i); pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    int  lat;
    int  strobes;
    bit  got;
    logic rdy, ordy;
    logic [31:0] rd;
    @(posedge clk); #1;
    set_port(v.port, v.addr, v.wdata, v.wmask, v.rstrb);
    got = 0; strobes = 0; lat = -1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      rdy  = v.port ? r1_ready : r0_ready;
      ordy = v.port ? r0_ready : r1_ready;
      rd   = v.port ? r1_rdata : r0_rdata;
      if (mem_rstrb || mem_wmask != 4'h0) begin
        strobes++;
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_rstrb", 32'(mem_rstrb), 32'(v.rstrb));
        chk("mem_wmask", 32'(mem_wmask), 32'(v.wmask));
        if (v.wmask != 4'h0) chk("mem_wdata", mem_wdata, v.wdata);
      end
      if (rdy) begin
        got = 1; lat = i;
        chk("rdata", rd, v.exp_rdata);
        chk("err", 32'(v.port ? r1_err : r0_err), 32'(v.exp_err));
        chk("other_ready", 32'(ordy), 0);
      end else begin
        chk("rdata_idle", rd, 0);
      end
    end
    chk("latency", 32'(lat), 2);
    chk("strobe_cycles", 32'(strobes), v.exp_err ? 0 : 1);
    @(posedge clk); #1;
    set_port(v.port, 0, 0, 4'h0, 1'b0);
  endtask

  int  order [$];
  bit  to0, to1;
  bit  bad_flag;
  int  exp_order [4];

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h2, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h0000_5600, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_1800, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0030, 32'hA5A5_A5A5, 4'hF, 1'b1, 32'h1111_1111, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 1'b1, 32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_17FC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_1800, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0013, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h7700_0000, 4'h8, 1'b0, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h77AD_BEEF, 1'b0};

    reset = 1'b1;
    set_port(1'b0, 0, 0, 4'h0, 1'b0);
    set_port(1'b1, 0, 0, 4'h0, 1'b0);
    preload(4, 32'hDEAD_BEEF);
    preload(12, 32'h1111_1111);
    preload(1535, 32'hCAFE_F00D);

    // Reset state: everything quiet.
    @(negedge clk);
    chk("rst_mem_rstrb", 32'(mem_rstrb), 0);
    chk("rst_mem_wmask", 32'(mem_wmask), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_r0_ready", 32'(r0_ready), 0);
    chk("rst_r1_ready", 32'(r1_ready), 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) do_txn(vecs[i]);

    // Reset during ISSUE aborts the read.
    @(posedge clk); #1;
    set_port(1'b0, 32'h10, 0, 4'h0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    set_port(1'b0, 0, 0, 4'h0, 1'b0);
    @(negedge clk);
    chk("abort_mem_rstrb", 32'(mem_rstrb), 0);
    chk("abort_r0_ready", 32'(r0_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bad_flag = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (r0_ready || mem_rstrb) bad_flag = 1;
    end
    chk("abort_quiet", 32'(bad_flag), 0);
    do_txn(vecs[6]);

    // Contention: both ports request two reads each, starting from a fresh reset.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    to0 = 0; to1 = 0;
    fork
      begin
        bit g0;
        for (int k = 0; k < 2; k++) begin
          set_port(1'b0, 32'h10, 0, 4'h0, 1'b1);
          g0 = 0;
          for (int i = 0; i < 30 && !g0; i++) begin
            @(negedge clk);
            if (r0_ready) begin g0 = 1; order.push_back(0); end
          end
          if (!g0) to0 = 1;
          @(posedge clk); #1;
        end
        set_port(1'b0, 0, 0, 4'h0, 1'b0);
      end
      begin
        bit g1;
        for (int k = 0; k < 2; k++) begin
          set_port(1'b1, 32'h17FC, 0, 4'h0, 1'b1);
          g1 = 0;
          for (int i = 0; i < 30 && !g1; i++) begin
            @(negedge clk);
            if (r1_ready) begin g1 = 1; order.push_back(1); end
          end
          if (!g1) to1 = 1;
          @(posedge clk); #1;
        end
        set_port(1'b1, 0, 0, 4'h0, 1'b0);
      end
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    chk("contend_timeout", {30'h0, to1, to0}, 0);
    chk("grant_count", 32'(order.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order[%0d]", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
          32'(exp_order[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
